// File: rtl/ladner_sub_pipe_8bit_if.sv
// Operand/result handshake bundle for the pipelined Ladner-Fischer subtractor.
// master drives operands and result-ready; slave is the subtractor itself.
`timescale 1ns/1ps
interface ladner_sub_pipe_8bit_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf
    );
endinterface

// File: rtl/ladner_sub_pipe_8bit.sv
// Three-stage 8-bit subtractor (a + ~b + 1) on a Ladner-Fischer prefix network.
// A single enable advances every stage at once, so a stalled output freezes the pipe.
`timescale 1ns/1ps
module ladner_sub_pipe_8bit (
    input logic                   clk,
    input logic                   rst_n,
    ladner_sub_pipe_8bit_if.slave bus
);

    logic       en;
    logic       v1, v2, v3;
    logic [7:0] bb;
    logic [7:0] g1, p1;
    logic [7:0] grp_g2, grp_p2, p2;
    logic [8:0] carry;
    logic [7:0] diff_q;
    logic       borrow_q, ovf_q;

    // Prefix nodes hold {G, P}; sXY means the span bits X down to Y.
    logic [1:0] s0, s1, s2, s3, s4, s5, s6, s7;
    logic [1:0] s10, s32, s54, s76;
    logic [1:0] s20, s30, s64, s74;
    logic [1:0] s40, s50, s60, s70;

    function automatic logic [1:0] lf_op(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
    endfunction

    assign en           = ~v3 | bus.out_ready;
    assign bus.in_ready = en;
    assign bb           = ~bus.b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            g1 <= '0;
            p1 <= '0;
        end else if (en) begin
            v1 <= bus.in_valid;
            g1 <= bus.a & bb;
            p1 <= bus.a ^ bb;
        end
    end

    assign s0 = {g1[0], p1[0]};
    assign s1 = {g1[1], p1[1]};
    assign s2 = {g1[2], p1[2]};
    assign s3 = {g1[3], p1[3]};
    assign s4 = {g1[4], p1[4]};
    assign s5 = {g1[5], p1[5]};
    assign s6 = {g1[6], p1[6]};
    assign s7 = {g1[7], p1[7]};

    assign s10 = lf_op(s1, s0);
    assign s32 = lf_op(s3, s2);
    assign s54 = lf_op(s5, s4);
    assign s76 = lf_op(s7, s6);

    assign s20 = lf_op(s2,  s10);
    assign s30 = lf_op(s32, s10);
    assign s64 = lf_op(s6,  s54);
    assign s74 = lf_op(s76, s54);

    assign s40 = lf_op(s4,  s30);
    assign s50 = lf_op(s54, s30);
    assign s60 = lf_op(s64, s30);
    assign s70 = lf_op(s74, s30);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            grp_g2 <= '0;
            grp_p2 <= '0;
            p2     <= '0;
        end else if (en) begin
            v2     <= v1;
            grp_g2 <= {s70[1], s60[1], s50[1], s40[1], s30[1], s20[1], s10[1], s0[1]};
            grp_p2 <= {s70[0], s60[0], s50[0], s40[0], s30[0], s20[0], s10[0], s0[0]};
            p2     <= p1;
        end
    end

    // Carry-in is 1 (the +1 of two's-complement negation), so c[i] = G | P.
    assign carry = {grp_g2 | grp_p2, 1'b1};

    // Bubbles load zeros so the result bus reads 0 whenever out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (en) begin
            v3 <= v2;
            if (v2) begin
                diff_q   <= p2 ^ carry[7:0];
                borrow_q <= ~carry[8];
                ovf_q    <= carry[8] ^ carry[7];
            end else begin
                diff_q   <= '0;
                borrow_q <= 1'b0;
                ovf_q    <= 1'b0;
            end
        end
    end

    assign bus.out_valid = v3;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.ovf       = ovf_q;

endmodule
